// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_ctrl
// Purpose  : Owns the fetch PC, accepts branch redirects, qualifies IMEM data
//            around the read latency and counts taken redirects.
//            Optional macro FETCH_MISALIGN_TRAP_EN adds a sticky trap on
//            misaligned redirect targets.
// Revision : 1.0
// ============================================================================
module fetch_pc_ctrl #(
   parameter int PC_W     = 9,
   parameter int IMEM_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             PcSel,
   input  logic [31:0]      BrPC,
   input  logic             Stall,
   output logic [PC_W-1:0]  PC,
   output logic             InstrValid,
   output logic             Flush,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic             MisalignTrap,
`endif
   output logic [CNT_W-1:0] RedirectCnt
);

   localparam int              LAT_W     = 2;
   localparam logic [1:0]      ST_BOOT   = 2'd0;
   localparam logic [1:0]      ST_RUN    = 2'd1;
   localparam logic [1:0]      ST_REFILL = 2'd2;
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(IMEM_LAT);
   localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
   localparam logic [PC_W-1:0]  PC_STEP  = PC_W'(4);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]       state_q, state_d;
   logic [LAT_W-1:0] bub_q, bub_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] rcnt_q, rcnt_d;
   logic [PC_W-1:0]  target;
   logic             redirect;
   logic             frozen;
   logic             unused_brpc;

   // Upper target bits are truncated; low bits are forced to a word boundary.
   assign target      = {BrPC[PC_W-1:2], 2'b00};
   assign unused_brpc = ^{BrPC[31:PC_W], BrPC[1:0]};

`ifdef FETCH_MISALIGN_TRAP_EN
   logic trap_q, trap_d;

   assign trap_d = trap_q | (redirect & (BrPC[1:0] != 2'b00));
   assign frozen = trap_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) trap_q <= 1'b0;
      else       trap_q <= trap_d;
   end

   assign MisalignTrap = trap_q;
`else
   assign frozen = 1'b0;
`endif

   assign redirect = PcSel & (state_q != ST_BOOT) & ~frozen;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_BOOT;
         bub_q   <= LAT_INIT;
         pc_q    <= '0;
         rcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         bub_q   <= bub_d;
         pc_q    <= pc_d;
         rcnt_q  <= rcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      bub_d   = bub_q;
      pc_d    = pc_q;
      rcnt_d  = rcnt_q;
      case (state_q)
         ST_BOOT: begin
            bub_d = bub_q - LAT_ONE;
            if (bub_q <= LAT_ONE) state_d = ST_RUN;
         end
         default: begin
            if (frozen) begin
               state_d = ST_REFILL;
            end else if (redirect) begin
               pc_d    = target;
               bub_d   = LAT_INIT;
               state_d = ST_REFILL;
               if (rcnt_q != '1) rcnt_d = rcnt_q + CNT_ONE;
            end else begin
               if (!Stall) pc_d = pc_q + PC_STEP;
               // The IMEM read is already in flight, so bubbles drain even when stalled.
               if (state_q == ST_REFILL) begin
                  bub_d = bub_q - LAT_ONE;
                  if (bub_q <= LAT_ONE) state_d = ST_RUN;
               end
            end
         end
      endcase
   end

   always_comb begin
      PC          = pc_q;
      RedirectCnt = rcnt_q;
      InstrValid  = (state_q == ST_RUN) & ~frozen;
      Flush       = redirect & ~reset;
   end

endmodule
`default_nettype wire

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Consumer end of the branch-redirect interface: accepts PcSel/BrPC from the EX-stage branch unit and owns the architectural fetch PC.
- Generates the instruction-memory fetch address, the pipeline squash pulse, and fetch-valid qualification around the synchronous IMEM read latency.
- Also keeps a saturating count of taken redirects for performance debug.

Parameters:
- PC_W, 9, width of the fetch PC / IMEM byte address.
- IMEM_LAT, 1, IMEM read latency in cycles (1..3); number of bubble cycles after boot or redirect.
- CNT_W, 16, width of the redirect counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- PcSel  in  1  redirect request from the branch unit; 1 = branch/jump taken this cycle.
- BrPC  in  32  redirect target; only meaningful when PcSel=1.
- Stall  in  1  hazard-unit hold; freezes the PC when no redirect is present.
- PC  out  PC_W  current fetch address to IMEM.
- InstrValid  out  1  IMEM data presented this cycle belongs to the current fetch stream.
- Flush  out  1  squash for IF/ID and ID/EX at the next clock edge.
- RedirectCnt  out  CNT_W  number of accepted redirects, saturating.
- MisalignTrap  out  1  only with FETCH_MISALIGN_TRAP_EN.

Behaviour:
- Reset (asynchronous, any state, including mid-flush):
  - PC=0, RedirectCnt=0, state=BOOT, bubble counter=IMEM_LAT, InstrValid=0, MisalignTrap=0.
  - Flush is 0 while reset is high.
- States:
  - BOOT: InstrValid=0. Counter decrements each cycle; on reaching 0, go to RUN. PC holds at 0 throughout BOOT.
  - RUN: InstrValid=1.
  - REFILL: InstrValid=0. Counter decrements each cycle; on reaching 0, go to RUN.
- Flush is combinational and equals PcSel in RUN and REFILL. It is 0 in BOOT.
- PC update priority at each rising edge (RUN/REFILL):
  1. If PcSel=1: PC <= {BrPC[PC_W-1:2], 2'b00}; counter <= IMEM_LAT; state <= REFILL; RedirectCnt increments, saturating at all-ones.
  2. Else if Stall=1: PC holds.
  3. Else: PC <= PC + 4, modulo 2^PC_W, so (2^PC_W - 4) wraps to 0.
- Redirect always wins over Stall.
- A redirect arriving in REFILL is accepted and restarts the counter at IMEM_LAT.
- PcSel in BOOT is ignored: no PC change, no count, Flush=0.
- The bubble counter decrements regardless of Stall, because the IMEM read is already in flight.
- BrPC[31:PC_W] is ignored; the target is truncated.
- Without the optional feature, BrPC[1:0] is silently forced to zero.
- Latency: the target appears on PC one cycle after PcSel. Its instruction is valid (InstrValid=1) IMEM_LAT cycles after that.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - On PcSel=1 with BrPC[1:0]!=0, the redirect is still taken (aligned as above) and MisalignTrap is set at that edge.
  - MisalignTrap is sticky until reset.
  - While MisalignTrap=1, the PC holds and InstrValid=0. The FSM stays in REFILL, and further PcSel is ignored (Flush stays 0).
- Not defined: the MisalignTrap port is absent, and the low bits are forced to zero with no side effect.

Test Plan:
- Release reset with Stall=0, PcSel=0 (IMEM_LAT=1) -> PC=0 and InstrValid=0 for 1 cycle; then PC sequence 0,4,8,C; InstrValid=1 from cycle 2.
- In RUN at PC=0x010, PcSel=1 with BrPC=0x0000_0040 -> Flush=1 that cycle; next PC=0x040, InstrValid=0 for 1 cycle, then PC 0x044 with InstrValid=1; RedirectCnt=1.
- Stall=1 and PcSel=1 in the same cycle, BrPC=0x080 -> PC=0x080 (redirect wins); with Stall=1 alone, the PC holds for 3 cycles.
- PC=0x1FC with PC_W=9, no stall -> next PC=0x000; BrPC=0xFFFF_F124 -> PC=0x124.
- Back-to-back redirects to 0x020 then 0x030 in consecutive cycles -> PC 0x020 then 0x030; REFILL restarts; RedirectCnt=2; assert reset mid-REFILL -> PC=0, state=BOOT, RedirectCnt=0 immediately.
- With FETCH_MISALIGN_TRAP_EN, BrPC=0x042 -> PC=0x040 and MisalignTrap=1; a later PcSel is ignored and the PC stays frozen until reset.
